// File: rtl/sha256_msg_padder_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_msg_padder_pkg;

    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned BLOCK_W     = 512;
    localparam int unsigned IDX_W       = 7;
    localparam int unsigned LEN_SLOT    = 56;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_FULL,
        PAD,
        WAIT_PADX,
        WAIT_LAST
    } state_t;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Byte-stream input and block output handshake of the message padder.
interface sha256_msg_padder_if;
    import sha256_msg_padder_pkg::*;

    logic [7:0]         data_in;
    logic               byte_rdy;
    logic               byte_stop;
    logic               in_ready;
    logic [BLOCK_W-1:0] block_data;
    logic               block_valid;
    logic               block_ready;
    logic               block_last;
    logic               overflow_err;

    // Producer of bytes and consumer of blocks.
    modport master (
        output data_in, byte_rdy, byte_stop, block_ready,
        input  in_ready, block_data, block_valid, block_last, overflow_err
    );

    // The padder itself.
    modport slave (
        input  data_in, byte_rdy, byte_stop, block_ready,
        output in_ready, block_data, block_valid, block_last, overflow_err
    );

endinterface

// File: rtl/sha256_msg_padder.sv
// Packs a byte stream into 512-bit SHA-256 blocks with FIPS 180-4 padding.
module sha256_msg_padder
    import sha256_msg_padder_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 1024,
    parameter int unsigned LEN_W     = 64
) (
    input  logic              clk,
    input  logic              rst,
    sha256_msg_padder_if.slave bus
);

    state_t             state, state_n;
    logic [IDX_W-1:0]   byte_idx, byte_idx_n;
    logic [LEN_W-1:0]   length, length_n;
    logic [BLOCK_W-1:0] block, block_n;
    logic               block_valid, block_valid_n;
    logic               block_last, block_last_n;
    logic               in_ready, in_ready_n;
    logic               overflow_err, overflow_err_n;
    logic               stop_pend, stop_pend_n;
    logic               discard, discard_n;

    logic                   handshake_c;
    logic                   wr_byte_c;
    logic [63:0]            bit_len_c;
    logic [BLOCK_BYTES-1:0] wr_en_c;
    logic [BLOCK_BYTES-1:0] zero_en_c;
    logic [BLOCK_W-1:0]     fill_c;
    logic [BLOCK_W-1:0]     pad_c;

    assign handshake_c = block_valid && bus.block_ready;
    assign bit_len_c   = 64'({length[LEN_W-4:0], 3'b000});

    // Per-byte enables: slot byte_idx takes the new byte or 0x80, later slots are zeroed by padding.
    for (genvar g = 0; g < BLOCK_BYTES; g++) begin : g_slot
        localparam int unsigned MSB = BLOCK_W - 1 - 8 * g;
        assign wr_en_c[g]       = (byte_idx == IDX_W'(g));
        assign zero_en_c[g]     = (byte_idx < IDX_W'(g));
        assign fill_c[MSB -: 8] = wr_en_c[g] ? bus.data_in : block[MSB -: 8];
        assign pad_c[MSB -: 8]  = wr_en_c[g] ? PAD_BYTE
                                : (zero_en_c[g] ? 8'h00 : block[MSB -: 8]);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            byte_idx     <= '0;
            length       <= '0;
            block        <= '0;
            block_valid  <= 1'b0;
            block_last   <= 1'b0;
            in_ready     <= 1'b1;
            overflow_err <= 1'b0;
            stop_pend    <= 1'b0;
            discard      <= 1'b0;
        end else begin
            state        <= state_n;
            byte_idx     <= byte_idx_n;
            length       <= length_n;
            block        <= block_n;
            block_valid  <= block_valid_n;
            block_last   <= block_last_n;
            in_ready     <= in_ready_n;
            overflow_err <= overflow_err_n;
            stop_pend    <= stop_pend_n;
            discard      <= discard_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n        = state;
        byte_idx_n     = byte_idx;
        length_n       = length;
        block_n        = block;
        block_last_n   = block_last;
        overflow_err_n = overflow_err;
        stop_pend_n    = stop_pend;
        discard_n      = discard;
        wr_byte_c      = 1'b0;

        // A byte offered while the padder is stalled is lost.
        if (bus.byte_rdy && !in_ready) begin
            overflow_err_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (bus.byte_rdy) begin
                    overflow_err_n = 1'b0;
                    wr_byte_c      = 1'b1;
                    state_n        = bus.byte_stop ? PAD : FILL;
                end else if (bus.byte_stop) begin
                    state_n = PAD;
                end
            end

            FILL: begin
                if (discard) begin
                    if (bus.byte_stop) begin
                        state_n   = IDLE;
                        discard_n = 1'b0;
                    end
                end else if (bus.byte_rdy && (length == LEN_W'(MAX_BYTES))) begin
                    overflow_err_n = 1'b1;
                    block_n        = '0;
                    byte_idx_n     = '0;
                    length_n       = '0;
                    if (bus.byte_stop) begin
                        state_n = IDLE;
                    end else begin
                        discard_n = 1'b1;
                    end
                end else if (bus.byte_rdy) begin
                    wr_byte_c = 1'b1;
                    if (byte_idx == IDX_W'(BLOCK_BYTES - 1)) begin
                        state_n     = WAIT_FULL;
                        stop_pend_n = bus.byte_stop;
                    end else if (bus.byte_stop) begin
                        state_n = PAD;
                    end
                end else if (bus.byte_stop) begin
                    state_n = PAD;
                end
            end

            WAIT_FULL: begin
                if (bus.byte_stop) begin
                    stop_pend_n = 1'b1;
                end
                if (handshake_c) begin
                    block_n     = '0;
                    byte_idx_n  = '0;
                    stop_pend_n = 1'b0;
                    state_n     = (stop_pend || bus.byte_stop) ? PAD : FILL;
                end
            end

            PAD: begin
                if (byte_idx <= IDX_W'(LEN_SLOT - 1)) begin
                    block_n      = {pad_c[BLOCK_W-1:64], bit_len_c};
                    block_last_n = 1'b1;
                    state_n      = WAIT_LAST;
                end else begin
                    block_n = pad_c;
                    state_n = WAIT_PADX;
                end
            end

            WAIT_PADX: begin
                if (handshake_c) begin
                    block_n      = BLOCK_W'(bit_len_c);
                    block_last_n = 1'b1;
                    state_n      = WAIT_LAST;
                end
            end

            WAIT_LAST: begin
                if (handshake_c) begin
                    block_n      = '0;
                    byte_idx_n   = '0;
                    length_n     = '0;
                    block_last_n = 1'b0;
                    state_n      = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        if (wr_byte_c) begin
            block_n    = fill_c;
            byte_idx_n = byte_idx + IDX_W'(1);
            length_n   = length + LEN_W'(1);
        end

        block_valid_n = (state_n == WAIT_FULL) || (state_n == WAIT_PADX) || (state_n == WAIT_LAST);
        in_ready_n    = (state_n == IDLE) || (state_n == FILL);
    end

    assign bus.in_ready     = in_ready;
    assign bus.block_data   = block;
    assign bus.block_valid  = block_valid;
    assign bus.block_last   = block_last;
    assign bus.overflow_err = overflow_err;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: a default build and a MAX_BYTES=8 build.
module tb_sha256_msg_padder;
    import sha256_msg_padder_pkg::*;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [511:0] data;
        logic         last;
    } exp_t;

    localparam logic [511:0] ABC_BLOCK = {32'h61626380, 416'h0, 64'h18};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]   din[2];
    logic         brdy[2];
    logic         bstop[2];
    logic         blk_rdy[2];
    logic [511:0] odata[2];
    logic         ovalid[2];
    logic         olast[2];
    logic         ordy[2];
    logic         oovf[2];
    int           rdy_mode[2] = '{2, 1};

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   checks = 0;
    int   errors = 0;

    sha256_msg_padder_if if_a ();
    sha256_msg_padder_if if_b ();

    sha256_msg_padder #(.MAX_BYTES(1024), .LEN_W(64)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    sha256_msg_padder #(.MAX_BYTES(8),    .LEN_W(64)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    assign if_a.data_in     = din[0];
    assign if_a.byte_rdy    = brdy[0];
    assign if_a.byte_stop   = bstop[0];
    assign if_a.block_ready = blk_rdy[0];
    assign if_b.data_in     = din[1];
    assign if_b.byte_rdy    = brdy[1];
    assign if_b.byte_stop   = bstop[1];
    assign if_b.block_ready = blk_rdy[1];
    assign odata[0]  = if_a.block_data;
    assign ovalid[0] = if_a.block_valid;
    assign olast[0]  = if_a.block_last;
    assign ordy[0]   = if_a.in_ready;
    assign oovf[0]   = if_a.overflow_err;
    assign odata[1]  = if_b.block_data;
    assign ovalid[1] = if_b.block_valid;
    assign olast[1]  = if_b.block_last;
    assign ordy[1]   = if_b.in_ready;
    assign oovf[1]   = if_b.overflow_err;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pad the whole message, then cut it into 64-byte blocks.
    task automatic push_expected(input int k, input bq_t msg);
        bq_t         p;
        logic [63:0] bl;
        exp_t        e;
        int          nb;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = p[64*b+j];
            e.last = (b == nb - 1);
            if (k == 0) exp_a.push_back(e);
            else        exp_b.push_back(e);
        end
    endtask

    task automatic mon_port(input int k);
        exp_t e;
        int   n;
        n = (k == 0) ? exp_a.size() : exp_b.size();
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL unexpected_block[%0d]: got block_valid=1 data=%0h, expected no block", k, odata[k]);
            return;
        end
        e = (k == 0) ? exp_a[0] : exp_b[0];
        check($sformatf("block_data[%0d]", k), odata[k], e.data);
        check($sformatf("block_last[%0d]", k), 512'(olast[k]), 512'(e.last));
        if (blk_rdy[k]) begin
            if (k == 0) void'(exp_a.pop_front());
            else        void'(exp_b.pop_front());
        end
    endtask

    // Monitor: every presented block is compared with the head of its queue; popped on acceptance.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (ovalid[0]) mon_port(0);
            if (ovalid[1]) mon_port(1);
        end
    end

    // Sink readiness: forced low, forced high, or random per port.
    initial begin
        blk_rdy[0] = 1'b0;
        blk_rdy[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++)
                blk_rdy[k] = (rdy_mode[k] == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode[k] == 1);
        end
    end

    task automatic drive_byte(input int k, input logic [7:0] b, input logic stop);
        int t = 0;
        while (!ordy[k] && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check($sformatf("in_ready_wait[%0d]", k), 512'(ordy[k]), 512'(1));
        din[k]   = b;
        brdy[k]  = 1'b1;
        bstop[k] = stop;
        @(posedge clk);
        #1;
        din[k]   = 8'h00;
        brdy[k]  = 1'b0;
        bstop[k] = 1'b0;
    endtask

    task automatic drive_stop(input int k);
        bstop[k] = 1'b1;
        @(posedge clk);
        #1;
        bstop[k] = 1'b0;
    endtask

    task automatic send_msg(input int k, input bq_t msg, input bit sep_stop, input int gap);
        for (int i = 0; i < msg.size(); i++) begin
            repeat ($urandom_range(0, gap)) begin
                @(posedge clk);
                #1;
            end
            drive_byte(k, msg[i], !sep_stop && (i == msg.size() - 1));
        end
        if (sep_stop || msg.size() == 0) drive_stop(k);
    endtask

    task automatic wait_idle(input int k);
        int t = 0;
        while ((((k == 0) ? exp_a.size() : exp_b.size()) != 0 || !ordy[k]) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check($sformatf("pending_blocks[%0d]", k), 512'((k == 0) ? exp_a.size() : exp_b.size()), 512'(0));
        check($sformatf("idle_in_ready[%0d]", k), 512'(ordy[k]), 512'(1));
    endtask

    // "abc" with stop on the last byte; valid must appear exactly two edges after the stop.
    task automatic test_abc(input int k);
        bq_t m;
        m = '{8'h61, 8'h62, 8'h63};
        rdy_mode[k] = 1;
        push_expected(k, m);
        drive_byte(k, 8'h61, 1'b0);
        check($sformatf("abc_ovf_cleared[%0d]", k), 512'(oovf[k]), 512'(0));
        drive_byte(k, 8'h62, 1'b0);
        drive_byte(k, 8'h63, 1'b1);
        check($sformatf("abc_valid_edge1[%0d]", k), 512'(ovalid[k]), 512'(0));
        @(posedge clk);
        #1;
        check($sformatf("abc_valid_edge2[%0d]", k), 512'(ovalid[k]), 512'(1));
        check($sformatf("abc_data[%0d]", k), odata[k], ABC_BLOCK);
        check($sformatf("abc_last[%0d]", k), 512'(olast[k]), 512'(1));
        wait_idle(k);
    endtask

    task automatic check_reset_outputs(input int k);
        check($sformatf("rst_valid[%0d]", k), 512'(ovalid[k]), 512'(0));
        check($sformatf("rst_last[%0d]", k), 512'(olast[k]), 512'(0));
        check($sformatf("rst_in_ready[%0d]", k), 512'(ordy[k]), 512'(1));
        check($sformatf("rst_ovf[%0d]", k), 512'(oovf[k]), 512'(0));
        check($sformatf("rst_data[%0d]", k), odata[k], 512'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t m;
        int  len;
        int  corner[10] = '{54, 55, 56, 57, 63, 64, 65, 119, 120, 128};

        for (int k = 0; k < 2; k++) begin
            din[k]   = 8'h00;
            brdy[k]  = 1'b0;
            bstop[k] = 1'b0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic "abc" block and its latency.
        test_abc(0);

        // Empty message.
        rdy_mode[0] = 2;
        m = {};
        push_expected(0, m);
        send_msg(0, m, 1'b1, 0);
        wait_idle(0);

        // 55 bytes fit in one block, 56 bytes spill into a length-only block.
        m = {};
        for (int i = 0; i < 55; i++) m.push_back(8'h41);
        push_expected(0, m);
        send_msg(0, m, 1'b0, 0);
        wait_idle(0);
        m.push_back(8'h41);
        push_expected(0, m);
        send_msg(0, m, 1'b0, 1);
        wait_idle(0);

        // Stalled full block: dropped byte sets overflow, stop is latched, block held steady.
        rdy_mode[0] = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
        push_expected(0, m);
        for (int i = 0; i < 64; i++) drive_byte(0, m[i], 1'b0);
        check("stall_in_ready", 512'(ordy[0]), 512'(0));
        check("stall_valid", 512'(ovalid[0]), 512'(1));
        check("stall_last", 512'(olast[0]), 512'(0));
        @(posedge clk);
        #1;
        din[0]  = 8'hEE;
        brdy[0] = 1'b1;
        @(posedge clk);
        #1;
        brdy[0] = 1'b0;
        din[0]  = 8'h00;
        check("drop_sets_overflow", 512'(oovf[0]), 512'(1));
        drive_stop(0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("stall_in_ready_late", 512'(ordy[0]), 512'(0));
        rdy_mode[0] = 1;
        wait_idle(0);
        check("overflow_sticky", 512'(oovf[0]), 512'(1));
        test_abc(0);

        // Asynchronous reset in the middle of a message.
        rdy_mode[0] = 2;
        for (int i = 0; i < 20; i++) drive_byte(0, 8'($urandom), 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs(0);
        @(posedge clk);
        #1;
        check_reset_outputs(0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_abc(0);

        // Randomized messages, many near the padding boundaries.
        rdy_mode[0] = 2;
        for (int n = 0; n < 40; n++) begin
            len = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 9)] : int'($urandom_range(0, 200));
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            push_expected(0, m);
            send_msg(0, m, ($urandom_range(0, 1) == 1), $urandom_range(0, 2));
            wait_idle(0);
            check("random_no_overflow", 512'(oovf[0]), 512'(0));
        end

        // MAX_BYTES=8 build: 9-byte messages are discarded without a block.
        rdy_mode[1] = 1;
        m = {};
        for (int i = 0; i < 9; i++) m.push_back(8'(i + 1));
        send_msg(1, m, 1'b0, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("long_msg_ovf", 512'(oovf[1]), 512'(1));
        check("long_msg_no_valid", 512'(ovalid[1]), 512'(0));
        wait_idle(1);
        test_abc(1);
        m.push_back(8'hAA);
        m.push_back(8'hBB);
        send_msg(1, m, 1'b1, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("long_msg_sep_ovf", 512'(oovf[1]), 512'(1));
        wait_idle(1);
        test_abc(1);

        check("final_queue_a", 512'(exp_a.size()), 512'(0));
        check("final_queue_b", 512'(exp_b.size()), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
